// File: rtl/counter52_expander.sv
// counter52_expander
//   Rebuilds canonical 5-bit thermometer words from a stream of 5:2-counter
//   (carry, sum) codes of weight 2*c + s. A small FIFO decouples producer
//   and consumer with valid/ready handshakes. A wrapping tally accumulates
//   the weight of every word handed to the consumer.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   TALLY_W  width of the emitted-weight tally (wraps modulo 2^TALLY_W)
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst        synchronous active-high reset
//   in_valid   producer presents a code
//   in_c       carry bit of the code (weight 2)
//   in_s       sum bit of the code (weight 1)
//   in_ready   block accepts a code this cycle
//   out_valid  out_x holds a valid word
//   out_x      thermometer word, low (2*c + s) bits set
//   out_ready  consumer takes out_x this cycle
//   level      current FIFO occupancy
//   tally      total weight of all words popped since reset
module counter52_expander #(
  parameter int DEPTH   = 4,
  parameter int TALLY_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_c,
  input  logic                     in_s,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [4:0]               out_x,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [TALLY_W-1:0]       tally
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  // Only the 2-bit weight is stored; the thermometer word is decoded at
  // the head, which keeps the storage narrow.
  logic [1:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [TALLY_W-1:0] tally_q, tally_d;

  logic [1:0] head_w;
  logic       push;
  logic       pop;

  assign head_w    = mem_q[rd_ptr_q];
  // Full/empty come from the occupancy count alone, so pointer equality
  // never has to be disambiguated.
  assign in_ready  = !rst && (level_q != FULL_LEVEL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = level_q;
  assign tally     = tally_q;

  // Bit gi is set when its index lies below the head weight; bits 3 and 4
  // can never satisfy this since the weight tops out at 3.
  for (genvar gi = 0; gi < 5; gi++) begin : g_decode
    assign out_x[gi] = out_valid && (3'(gi) < {1'b0, head_w});
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    tally_d  = tally_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      tally_d  = tally_q + TALLY_W'(head_w);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tally_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      tally_q  <= tally_d;
    end
  end

  // Storage needs no reset; push is already suppressed while rst is high
  // because in_ready is forced low.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_c, in_s};
    end
  end

endmodule

// File: tb/tb_counter52_expander.sv
module tb_counter52_expander;

  localparam int DEPTH   = 4;
  localparam int TALLY_W = 4;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_c = 1'b0;
  logic               in_s = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic [4:0]         out_x;
  logic               out_ready = 1'b0;
  logic [LVL_W-1:0]   level;
  logic [TALLY_W-1:0] tally;

  counter52_expander #(.DEPTH(DEPTH), .TALLY_W(TALLY_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_c      (in_c),
    .in_s      (in_s),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_ready (out_ready),
    .level     (level),
    .tally     (tally)
  );

  always #5 clk = ~clk;

  // Reference model: the queue holds the weights of codes inside the FIFO,
  // front = next word to be presented. It is the scoreboard.
  int sb[$];
  int tally_exp = 0;
  bit push_pend = 1'b0;
  int pend_w = 0;
  int n_tests = 0;
  int n_fail = 0;

  function automatic int thermo(input int w);
    return (2 ** w) - 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: commit the push accepted at the edge just passed,
  // then drive new inputs and predict whether they will be accepted.
  task automatic step(input bit r, input bit v, input bit c, input bit s, input bit o);
    @(posedge clk);
    #1;
    if (push_pend) sb.push_back(pend_w);
    rst       = r;
    in_valid  = v;
    in_c      = c;
    in_s      = s;
    out_ready = o;
    push_pend = v && !r && (sb.size() < DEPTH);
    pend_w    = 2 * int'(c) + int'(s);
  endtask

  // Monitor: mid-cycle, compare every output with the model, then retire
  // the head if the consumer takes it at the coming edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("in_ready", int'(in_ready), int'(!rst && (sb.size() < DEPTH)));
      check("level", int'(level), sb.size());
      check("out_valid", int'(out_valid), int'(sb.size() != 0));
      check("out_x", int'(out_x), (sb.size() != 0) ? thermo(sb[0]) : 0);
      check("tally", int'(tally), tally_exp);
      if (rst) begin
        sb.delete();
        tally_exp = 0;
      end else if (sb.size() != 0 && out_ready) begin
        int w;
        w = sb.pop_front();
        tally_exp = (tally_exp + w) % (2 ** TALLY_W);
        $display("[TB] pop w=%0d out_x=%b tally_next=%0d", w, out_x, tally_exp);
      end
    end
  end

  initial begin
    // Reset held three cycles with codes applied.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1);
    // Decode sweep with consumer always ready.
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 1);
    // Fill and stall: five (1,1) pushes, only four fit.
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    // Full: pop and push together -> pop only.
    step(0, 1, 1, 1, 1);
    // Concurrent push/pop at partial occupancy.
    step(0, 1, 1, 0, 1);
    step(0, 1, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    // Tally wrap: six w=3 words drained.
    for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    // Reset mid-stream: three entries, then rst with push and pop.
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // Randomised traffic with rare resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter52_expander.md
# counter52_expander

Receive-side companion to the 5:2 counter. The counter compresses a 5-bit word into a weighted (carry, sum) code of value 2·c + s. This block takes a stream of such codes and regenerates a canonical 5-bit thermometer word holding the same weight. A small FIFO decouples producer and consumer with valid/ready handshakes, and a running tally tracks the total weight emitted. It sits between the compressor array and any downstream checker or serialiser that needs bit-level words back.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- TALLY_W, 16: width of the emitted-weight tally; wraps modulo 2^TALLY_W.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a code.
- in_c  input  1  carry bit of the code, weight 2.
- in_s  input  1  sum bit of the code, weight 1.
- in_ready  output  1  block accepts a code this cycle.
- out_valid  output  1  out_x holds a valid word.
- out_x  output  5  thermometer word; the low (2·c + s) bits are 1, the rest 0.
- out_ready  input  1  consumer takes out_x this cycle.
- level  output  log2(DEPTH)+1  current FIFO occupancy.
- tally  output  TALLY_W  sum of weights of all words popped since reset.

## Operation
- **Push:** fires when in_valid && in_ready. Stores the 2-bit weight w = {in_c, in_s}, range 0..3, at the write pointer.
- **Pop:** fires when out_valid && out_ready. Advances the read pointer and adds w of the head entry to tally.
- **Decode:** out_x = (5'b1 << w) − 1, taken from the head entry.
  - w=0 gives 00000, w=1 gives 00001, w=2 gives 00011, w=3 gives 00111.
  - out_x[4:3] are always 0.
  - out_x = 00000 whenever out_valid = 0.
- **Handshake signals:**
  - in_ready = !rst && (level != DEPTH). A full FIFO does not accept a push in the same cycle as a pop.
  - out_valid = (level != 0). There is no combinational bypass; an empty FIFO never presents the incoming code.
- **Simultaneous push and pop:** when level ≥ 1, both occur and level is unchanged.
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided from level only, never from pointer equality.
- **Tally wrap:** tally wraps silently from 2^TALLY_W − 1 to a small value. There is no saturation and no flag.
- **Input hold rules:**
  - in_c and in_s are sampled only on a push.
  - Input values while in_valid = 0 are ignored.
  - A producer that drops in_valid before acceptance loses that code; no protocol violation is flagged.
- **Consumer stability:** out_x and out_valid stay stable while out_valid && !out_ready.

## Timing
- **Reset:**
  - rst high at a rising edge clears level, both pointers and tally to 0.
  - Resulting outputs: out_valid = 0, out_x = 00000, in_ready = 0 while rst is high.
  - Storage contents are don't-care.
- **Reset mid-operation:** rst asserted alongside a push or pop overrides both. Nothing is stored, nothing is popped, and tally still clears.
- **Latency:** a code pushed at edge N appears on out_valid/out_x in the cycle after edge N. Minimum latency is 1 cycle.
- **Throughput:** 1 word per cycle sustained whenever 0 < level < DEPTH and both sides are ready.
- **Tally and level timing:** tally and level update at the same edge as the pop or push that changes them.

## Test plan
- **Reset:** hold rst 3 cycles with in_valid = 1 and codes applied → level = 0, tally = 0, out_valid = 0, in_ready = 0. After release, in_ready = 1 on the first cycle.
- **Decode sweep:** push codes (0,0), (0,1), (1,0), (1,1) with out_ready = 1 → out_x = 00000, 00001, 00011, 00111, each one cycle after its push. Final tally = 6.
- **Fill and stall:** out_ready = 0, push 5 codes of (1,1) with DEPTH = 4 → first 4 accepted, in_ready = 0 on the 5th, level = 4. Raise out_ready and push in the same cycle → pop only, level = 3.
- **Concurrent push/pop:** level = 2, push (1,0) while popping a head of w=1 → level stays 2, tally += 1, later output order preserved.
- **Tally wrap:** TALLY_W = 4, pop six w=3 words → tally sequence 3, 6, 9, 12, 15, 2.
- **Reset mid-stream:** level = 3 with tally = 7, assert rst together with a push and a pop → next cycle level = 0, tally = 0, out_valid = 0. The pushed code never appears.
